// File: rtl/l2_line_ctrl_pkg.sv
// Shared types and defaults for the L2 line controller: FSM states, the grant
// encoding and the default geometry.
package l2_ctrl_pkg;

  localparam int L2_CHECK_LINE = 128;
  localparam int L2_TAG_W      = 20;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB,
    REFILL,
    DONE
  } l2_state_e;

  typedef enum logic {
    GRANT_INST,
    GRANT_DATA
  } l2_grant_e;

  function automatic logic is_hit(input logic valid, input logic match);
    return valid & match;
  endfunction

endpackage

// File: rtl/l2_line_ctrl_if.sv
// Bundle of the L1 request ports, the check-set/tag-array ports and the memory
// port. The controller uses the master view; the surrounding system uses slave.
interface l2_line_ctrl_if #(
  parameter int IDX_W = 7,
  parameter int TAG_W = 20
);
  logic             inst_req;
  logic [IDX_W-1:0] inst_index;
  logic [TAG_W-1:0] inst_tag;
  logic             inst_ack;
  logic             data_req;
  logic             data_wr;
  logic [IDX_W-1:0] data_index;
  logic [TAG_W-1:0] data_tag;
  logic             data_ack;
  logic [IDX_W-1:0] chk_index;
  logic             valid_chk;
  logic             dirty_chk;
  logic             tag_match;
  logic [TAG_W-1:0] tag_q;
  logic             tag_we;
  logic             valid_set;
  logic             dirty_set;
  logic             dirty_clear;
  logic             mem_req;
  logic             mem_we;
  logic             mem_ready;

  modport master (
    input  inst_req, inst_index, inst_tag, data_req, data_wr, data_index,
           data_tag, valid_chk, dirty_chk, tag_match, mem_ready,
    output inst_ack, data_ack, chk_index, tag_q, tag_we, valid_set,
           dirty_set, dirty_clear, mem_req, mem_we
  );

  modport slave (
    output inst_req, inst_index, inst_tag, data_req, data_wr, data_index,
           data_tag, valid_chk, dirty_chk, tag_match, mem_ready,
    input  inst_ack, data_ack, chk_index, tag_q, tag_we, valid_set,
           dirty_set, dirty_clear, mem_req, mem_we
  );
endinterface

// File: rtl/l2_line_ctrl_arbiter.sv
// Two-requester round-robin arbiter. Grant is combinational; the last winner
// is remembered only when the controller accepts the grant.
module l2_req_arbiter
  import l2_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      inst_req,
  input  logic      data_req,
  input  logic      accept,
  output l2_grant_e grant,
  output logic      grant_vld
);

  l2_grant_e last_grant;

  always_comb begin
    grant_vld = inst_req | data_req;
    grant     = GRANT_DATA;
    if (inst_req && data_req) begin
      grant = (last_grant == GRANT_INST) ? GRANT_DATA : GRANT_INST;
    end else if (inst_req) begin
      grant = GRANT_INST;
    end
  end

  // Reset to DATA so the first contention goes to the instruction side
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= GRANT_DATA;
    end else if (accept && grant_vld) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/l2_line_ctrl.sv
// Per-request controller of the direct-mapped L2: arbitrates L1-I/L1-D misses,
// then sequences lookup, writeback and refill and drives the check-set strobes.
module l2_line_ctrl
  import l2_ctrl_pkg::*;
#(
  parameter int CHECK_LINE = L2_CHECK_LINE,
  parameter int TAG_W      = L2_TAG_W
) (
  input logic           clk,
  input logic           rst_n,
  l2_line_ctrl_if.master bus
);

  localparam int IDX_W = $clog2(CHECK_LINE);

  l2_state_e        state;
  l2_state_e        state_nxt;
  logic [IDX_W-1:0] chk_index;
  logic [TAG_W-1:0] tag_q;
  logic             wr_q;
  logic             is_inst_q;
  l2_grant_e        grant;
  logic             grant_vld;
  logic             accept;
  logic             ack;
  logic             valid_set;
  logic             dirty_set;
  logic             dirty_clear;
  logic             tag_we;
  logic             mem_req;
  logic             mem_we;

  assign accept = (state == IDLE) && grant_vld;

  l2_req_arbiter u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .inst_req  (bus.inst_req),
    .data_req  (bus.data_req),
    .accept    (accept),
    .grant     (grant),
    .grant_vld (grant_vld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      chk_index <= '0;
      tag_q     <= '0;
      wr_q      <= 1'b0;
      is_inst_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        is_inst_q <= (grant == GRANT_INST);
        if (grant == GRANT_INST) begin
          chk_index <= bus.inst_index;
          tag_q     <= bus.inst_tag;
          wr_q      <= 1'b0;
        end else begin
          chk_index <= bus.data_index;
          tag_q     <= bus.data_tag;
          wr_q      <= bus.data_wr;
        end
      end
    end
  end

  // Strobes are decoded from the state so an async reset clears them at once
  always_comb begin
    state_nxt   = state;
    ack         = 1'b0;
    valid_set   = 1'b0;
    dirty_set   = 1'b0;
    dirty_clear = 1'b0;
    tag_we      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (is_hit(bus.valid_chk, bus.tag_match)) begin
          ack       = 1'b1;
          dirty_set = wr_q;
          state_nxt = IDLE;
        end else if (bus.valid_chk && bus.dirty_chk) begin
          state_nxt = WB;
        end else begin
          state_nxt = REFILL;
        end
      end
      WB: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (bus.mem_ready) begin
          dirty_clear = 1'b1;
          state_nxt   = REFILL;
        end
      end
      REFILL: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          valid_set = 1'b1;
          tag_we    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        ack       = 1'b1;
        dirty_set = wr_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.chk_index   = chk_index;
  assign bus.tag_q       = tag_q;
  assign bus.inst_ack    = ack & is_inst_q;
  assign bus.data_ack    = ack & ~is_inst_q;
  assign bus.valid_set   = valid_set;
  assign bus.dirty_set   = dirty_set;
  assign bus.dirty_clear = dirty_clear;
  assign bus.tag_we      = tag_we;
  assign bus.mem_req     = mem_req;
  assign bus.mem_we      = mem_we;

  // A granted requester must hold its request until it sees its ack
  inst_held_a: assert property (@(posedge clk) disable iff (!rst_n)
    (state != IDLE && is_inst_q) |-> bus.inst_req);
  data_held_a: assert property (@(posedge clk) disable iff (!rst_n)
    (state != IDLE && !is_inst_q) |-> bus.data_req);
  dirty_excl_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(dirty_set && dirty_clear));

endmodule

// File: tb/tb_l2_line_ctrl.sv
// Bench for l2_line_ctrl: emulated check-set/tag arrays and memory around the
// DUT, directed scenarios, then random requests against a line-level cache model.
module tb_l2_line_ctrl;

  localparam int CHECK_LINE = 128;
  localparam int IDX_W      = $clog2(CHECK_LINE);
  localparam int TAG_W      = 20;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  l2_line_ctrl_if #(.IDX_W(IDX_W), .TAG_W(TAG_W)) bus ();

  l2_line_ctrl #(.CHECK_LINE(CHECK_LINE), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Environment: VALID/DIRTY check-set units and tag array driven by DUT strobes
  bit             env_valid [CHECK_LINE];
  bit             env_dirty [CHECK_LINE];
  bit [TAG_W-1:0] env_tag   [CHECK_LINE];

  assign bus.valid_chk = env_valid[bus.chk_index];
  assign bus.dirty_chk = env_dirty[bus.chk_index];
  assign bus.tag_match = (env_tag[bus.chk_index] == bus.tag_q);

  always @(posedge clk) begin
    if (bus.valid_set) env_valid[bus.chk_index] <= 1'b1;
    if (bus.tag_we)    env_tag[bus.chk_index]   <= bus.tag_q;
    if (bus.dirty_set) env_dirty[bus.chk_index] <= 1'b1;
    else if (bus.dirty_clear) env_dirty[bus.chk_index] <= 1'b0;
  end

  // Memory: completes each held request after mem_delay cycles
  int mem_delay = 2;
  int mem_cnt   = 0;
  bit stray_en  = 1'b0;

  always begin
    @(posedge clk);
    #1;
    if (!bus.mem_req) begin
      mem_cnt       = 0;
      bus.mem_ready = stray_en && ($urandom_range(0, 3) == 0);
    end else begin
      mem_cnt++;
      if (mem_cnt >= mem_delay) begin
        bus.mem_ready = 1'b1;
        mem_cnt       = 0;
      end else begin
        bus.mem_ready = 1'b0;
      end
    end
  end

  // Reference cache contents, updated once per completed transaction
  bit             m_valid [CHECK_LINE];
  bit             m_dirty [CHECK_LINE];
  bit [TAG_W-1:0] m_tag   [CHECK_LINE];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_req(input bit is_inst, input int idx, input int tg,
                        input bit wr, input int d);
    bit hit, dmiss, eff_wr, ack_inst, ack_both, ds_at_ack;
    int exp_ack, c, ack_c;
    int n_wb, n_rf, n_dc, n_vs, n_tw, n_ds, n_both;
    eff_wr  = is_inst ? 1'b0 : wr;
    hit     = m_valid[idx] && (m_tag[idx] == TAG_W'(tg));
    dmiss   = !hit && m_valid[idx] && m_dirty[idx];
    exp_ack = hit ? 1 : (dmiss ? 2 + 2 * d : 2 + d);
    n_wb = 0; n_rf = 0; n_dc = 0; n_vs = 0; n_tw = 0; n_ds = 0; n_both = 0;
    ack_inst = 0; ack_both = 0; ds_at_ack = 0;
    mem_delay = d;
    @(posedge clk);
    #1;
    if (is_inst) begin
      bus.inst_req   = 1'b1;
      bus.inst_index = IDX_W'(idx);
      bus.inst_tag   = TAG_W'(tg);
    end else begin
      bus.data_req   = 1'b1;
      bus.data_index = IDX_W'(idx);
      bus.data_tag   = TAG_W'(tg);
      bus.data_wr    = wr;
    end
    c = 0;
    ack_c = -1;
    while (ack_c < 0 && c < 200) begin
      @(negedge clk);
      if (c == 1) begin
        chk("lookup_index", bus.chk_index, idx);
        chk("lookup_tag", bus.tag_q, tg);
      end
      if (bus.mem_req && bus.mem_we)  n_wb++;
      if (bus.mem_req && !bus.mem_we) n_rf++;
      n_dc += int'(bus.dirty_clear);
      n_vs += int'(bus.valid_set);
      n_tw += int'(bus.tag_we);
      n_ds += int'(bus.dirty_set);
      if (bus.dirty_set && bus.dirty_clear) n_both++;
      if (bus.inst_ack || bus.data_ack) begin
        ack_c     = c;
        ack_inst  = bus.inst_ack;
        ack_both  = bus.inst_ack && bus.data_ack;
        ds_at_ack = bus.dirty_set;
      end
      c++;
      @(posedge clk);
      #1;
    end
    bus.inst_req = 1'b0;
    bus.data_req = 1'b0;
    chk("ack_cycle", ack_c, exp_ack);
    chk("ack_side", ack_inst, is_inst);
    chk("ack_single", ack_both, 0);
    chk("dirty_set_at_ack", ds_at_ack, eff_wr);
    chk("dirty_set_count", n_ds, eff_wr);
    chk("dirty_both", n_both, 0);
    chk("wb_cycles", n_wb, dmiss ? d : 0);
    chk("refill_cycles", n_rf, hit ? 0 : d);
    chk("dirty_clear_count", n_dc, dmiss ? 1 : 0);
    chk("valid_set_count", n_vs, hit ? 0 : 1);
    chk("tag_we_count", n_tw, hit ? 0 : 1);
    m_dirty[idx] = hit ? (m_dirty[idx] | eff_wr) : eff_wr;
    m_valid[idx] = 1'b1;
    m_tag[idx]   = TAG_W'(tg);
    chk("line_valid", env_valid[idx], m_valid[idx]);
    chk("line_dirty", env_dirty[idx], m_dirty[idx]);
    chk("line_tag", env_tag[idx], m_tag[idx]);
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, {bus.mem_req, bus.mem_we, bus.inst_ack, bus.data_ack, bus.valid_set,
              bus.dirty_set, bus.dirty_clear, bus.tag_we}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit g_inst;
    bus.inst_req   = 1'b0;
    bus.inst_index = '0;
    bus.inst_tag   = '0;
    bus.data_req   = 1'b0;
    bus.data_wr    = 1'b0;
    bus.data_index = '0;
    bus.data_tag   = '0;
    #1;
    chk_quiet("reset_strobes");
    chk("reset_index", bus.chk_index, 0);
    chk("reset_tag", bus.tag_q, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Read fill then read hit, write fill then write hit
    do_req(1'b0, 5, 'h11, 1'b0, 2);
    do_req(1'b0, 5, 'h11, 1'b0, 2);
    do_req(1'b0, 7, 'h22, 1'b1, 1);
    do_req(1'b0, 7, 'h22, 1'b1, 1);
    // Clean instruction miss with 4-cycle memory, then dirty write miss
    do_req(1'b1, 3, 'h33, 1'b0, 4);
    do_req(1'b0, 7, 'h44, 1'b1, 3);

    // Contention from reset: both held, all hits
    @(posedge clk);
    #1;
    rst_n          = 1'b0;
    bus.inst_req   = 1'b1;
    bus.inst_index = IDX_W'(3);
    bus.inst_tag   = TAG_W'('h33);
    bus.data_req   = 1'b1;
    bus.data_index = IDX_W'(5);
    bus.data_tag   = TAG_W'('h11);
    bus.data_wr    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    g_inst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k % 2 == 1 && k < 8) begin
        g_inst = !g_inst;
        chk("rr_inst_ack", bus.inst_ack, g_inst);
        chk("rr_data_ack", bus.data_ack, !g_inst);
        chk("rr_index", bus.chk_index, g_inst ? 3 : 5);
      end else begin
        chk("rr_gap_acks", {bus.inst_ack, bus.data_ack}, 0);
      end
      if (k == 7) begin
        @(posedge clk);
        #1;
        bus.inst_req = 1'b0;
        bus.data_req = 1'b0;
      end
    end

    // Reset in the middle of a refill
    mem_delay = 10;
    @(posedge clk);
    #1;
    bus.data_req   = 1'b1;
    bus.data_index = IDX_W'(100);
    bus.data_tag   = TAG_W'('h55);
    bus.data_wr    = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("pre_reset_mem_req", bus.mem_req, 1);
    rst_n        = 1'b0;
    bus.data_req = 1'b0;
    #1;
    chk_quiet("async_reset_strobes");
    chk("async_reset_index", bus.chk_index, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 100, 'h55, 1'b1, 2);

    // Random traffic over a small set of lines and tags
    stray_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      do_req(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             int'($urandom_range(1, 5)));
    end
    stray_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
